conv_loop_seq: RTL

//  Loop sequencer directly upstream of the conv PE. Latches layer dims on a start pulse and walks
//  row (outer) -> in-channel group (middle) -> column (inner), one position per cycle.

---
 rtl/conv_loop_seq_pkg.sv | 31 +++
 rtl/conv_loop_seq_if.sv | 42 ++++
 rtl/conv_loop_cnt.sv | 32 +++
 rtl/conv_loop_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/conv_loop_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_loop_seq_pkg
//  Description : Shared parameters and FSM state encoding for the conv loop
//                sequencer.
//  Revision    : 1.0
// ============================================================================
package conv_loop_seq_pkg;

    localparam int BM_DATA_DELAY = 2;
    localparam int MAC_DELAY     = 4;

    localparam int DEF_W_SIZE    = 9;
    localparam int DEF_W_CHANNEL = 9;
    localparam int DEF_DRAIN_CYC = BM_DATA_DELAY + MAC_DELAY;
    localparam int DEF_W_DRAIN   = 3;

    localparam logic [1:0] CTRL_SEQ_IDLE  = 2'd0;
    localparam logic [1:0] CTRL_SEQ_RUN   = 2'd1;
    localparam logic [1:0] CTRL_SEQ_DRAIN = 2'd2;
    localparam logic [1:0] CTRL_SEQ_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = CTRL_SEQ_IDLE,
        ST_RUN   = CTRL_SEQ_RUN,
        ST_DRAIN = CTRL_SEQ_DRAIN,
        ST_DONE  = CTRL_SEQ_DONE
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_loop_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_loop_seq_if
//  Description : Layer-control and PE-position bundle of the loop sequencer.
//  Revision    : 1.0
// ============================================================================
interface conv_loop_seq_if #(
    parameter int W_SIZE    = 9,
    parameter int W_CHANNEL = 9
);
    logic                 i_start;
    logic [W_SIZE-1:0]    i_width;
    logic [W_SIZE-1:0]    i_height;
    logic [W_CHANNEL-1:0] i_chn_groups;
    logic                 i_stall;

    logic                 o_ctrl_data_run;
    logic [W_SIZE-1:0]    o_row;
    logic [W_SIZE-1:0]    o_col;
    logic [W_CHANNEL-1:0] o_chn;
    logic                 o_is_first_row;
    logic                 o_is_last_row;
    logic                 o_is_first_col;
    logic                 o_is_last_col;
    logic                 o_busy;
    logic                 o_layer_done;

    modport master (
        input  i_start, i_width, i_height, i_chn_groups, i_stall,
        output o_ctrl_data_run, o_row, o_col, o_chn,
               o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
               o_busy, o_layer_done
    );

    modport slave (
        output i_start, i_width, i_height, i_chn_groups, i_stall,
        input  o_ctrl_data_run, o_row, o_col, o_chn,
               o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
               o_busy, o_layer_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_loop_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : conv_loop_cnt
//  Description : Wrapping counter 0..max with synchronous clear and enable.
//  Revision    : 1.0
// ============================================================================
module conv_loop_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == max);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_loop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : conv_loop_seq
//  Description : Walks row -> channel group -> column, one position per cycle,
//                then waits out the PE pipeline and pulses layer done.
//  Revision    : 1.0
// ============================================================================
module conv_loop_seq
    import conv_loop_seq_pkg::*;
#(
    parameter int W_SIZE    = DEF_W_SIZE,
    parameter int W_CHANNEL = DEF_W_CHANNEL,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int W_DRAIN   = DEF_W_DRAIN
) (
    input  logic           clk,
    input  logic           rstn,
    conv_loop_seq_if.master bus
);

    seq_state_t           r_state;
    seq_state_t           w_next;
    logic [W_SIZE-1:0]    r_width;
    logic [W_SIZE-1:0]    r_height;
    logic [W_CHANNEL-1:0] r_chn_groups;
    logic                 r_run;
    logic                 r_busy;
    logic                 r_done;
    logic [W_DRAIN-1:0]   r_drain;

    logic                 w_accept;
    logic                 w_zero_dim;
    logic                 w_run_nxt;
    logic                 w_walk_end;
    logic                 w_col_last;
    logic                 w_chn_last;
    logic                 w_row_last;
    logic [W_SIZE-1:0]    w_col;
    logic [W_SIZE-1:0]    w_row;
    logic [W_CHANNEL-1:0] w_chn;

    assign w_accept   = (r_state == ST_IDLE) && bus.i_start;
    assign w_zero_dim = (bus.i_width == '0) || (bus.i_height == '0) || (bus.i_chn_groups == '0);
    assign w_walk_end = r_run && w_col_last && w_chn_last && w_row_last;

    always_comb begin
        w_next    = r_state;
        w_run_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (w_zero_dim) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next    = ST_RUN;
                        w_run_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_walk_end) begin
                    w_next = (DRAIN_CYC == 1) ? ST_DONE : ST_DRAIN;
                end else begin
                    w_run_nxt = !bus.i_stall;
                end
            end
            // DONE is itself the last drain cycle; done is registered out of it.
            ST_DRAIN: begin
                if (r_drain == W_DRAIN'(DRAIN_CYC - 2)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_chn_groups <= '0;
            r_run        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drain      <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= w_run_nxt;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
            if (w_accept) begin
                r_width      <= bus.i_width;
                r_height     <= bus.i_height;
                r_chn_groups <= bus.i_chn_groups;
            end
            if (r_state == ST_DRAIN) begin
                r_drain <= r_drain + W_DRAIN'(1);
            end else begin
                r_drain <= '0;
            end
        end
    end

    // Counters step only on issued cycles, so a stalled position is held.
    conv_loop_cnt #(.W(W_SIZE)) u_col (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_accept),
        .en   (r_run),
        .max  (r_width - W_SIZE'(1)),
        .cnt  (w_col),
        .last (w_col_last)
    );

    conv_loop_cnt #(.W(W_CHANNEL)) u_chn (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_accept),
        .en   (r_run && w_col_last),
        .max  (r_chn_groups - W_CHANNEL'(1)),
        .cnt  (w_chn),
        .last (w_chn_last)
    );

    conv_loop_cnt #(.W(W_SIZE)) u_row (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_accept),
        .en   (r_run && w_col_last && w_chn_last),
        .max  (r_height - W_SIZE'(1)),
        .cnt  (w_row),
        .last (w_row_last)
    );

    assign bus.o_ctrl_data_run = r_run;
    assign bus.o_row           = w_row;
    assign bus.o_col           = w_col;
    assign bus.o_chn           = w_chn;
    assign bus.o_busy          = r_busy;
    assign bus.o_layer_done    = r_done;

    // Gated by busy so that every output reads 0 out of reset.
    assign bus.o_is_first_row = r_busy && (w_row == '0);
    assign bus.o_is_last_row  = r_busy && w_row_last;
    assign bus.o_is_first_col = r_busy && (w_col == '0);
    assign bus.o_is_last_col  = r_busy && w_col_last;

endmodule
`default_nettype wire
